uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal values 4 or greater.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 run  input  1  transmit request; sampled each clk.
REQ-005 din  input  8  byte to transmit; captured when a request is accepted.
REQ-006 rx  input  1  serial receive line, asynchronous, idle high.
REQ-007 tx  output  1  serial transmit line, idle high.
REQ-008 dout  output  8  last received byte.
REQ-009 done  output  1  one-cycle pulse when a received frame completes.
REQ-010 err  output  1  framing-error flag for the most recently completed frame.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-012 Transmitter states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: tx=1; run=1 accepts the request, latches din, and enters START on the next edge.
REQ-014 START drives tx=0, DATA drives din[0..7] in order, STOP drives tx=1; each bit is held exactly CLKS_PER_BIT cycles.
REQ-015 Frame length SHALL be 10*CLKS_PER_BIT cycles; tx falls on the cycle after run is sampled.
REQ-016 After STOP the transmitter SHALL return to IDLE.
REQ-017 run=1 held continuously SHALL produce back-to-back frames with no extra idle cycles.
REQ-018 run and din changes during a frame SHALL be ignored; the latched byte is sent unaltered.
REQ-019 rx SHALL pass through a 2-flop synchronizer before use.
REQ-020 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-021 A synchronized falling edge on rx in IDLE SHALL enter START.
REQ-022 rx is sampled at mid-bit: CLKS_PER_BIT/2 cycles into the start bit (integer division), then every CLKS_PER_BIT cycles.
REQ-023 False start: if rx=1 at the mid-start sample, the receiver returns to IDLE with no done pulse and no change to dout or err.
REQ-024 DATA: 8 samples shifted in LSB first.
REQ-025 At the mid-stop sample, dout is updated with the received byte and done pulses high for exactly one cycle.
REQ-026 err is updated in the same cycle as done: 1 if the sampled stop bit was 0, else 0.
REQ-027 dout and err SHALL hold their values until the next completed frame.
REQ-028 After the stop sample the receiver SHALL return to IDLE and may detect a new start edge immediately.
REQ-029 The transmitter and receiver SHALL operate fully independently and concurrently.
REQ-030 Looping tx to rx SHALL return din unchanged on dout.

Reset
REQ-031 rst_n low SHALL immediately force tx=1, dout=0x00, done=0, err=0, both FSMs to IDLE, all counters to 0, and synchronizer flops to 1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse; operation resumes in IDLE on the first edge after release.
REQ-033 run held high during reset SHALL be sampled on the first clk edge after release.

Verification
REQ-034 Loopback, CLKS_PER_BIT=16, run pulse with din=0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1, 16 cycles per bit; done pulses once; dout=0xA5; err=0.
REQ-035 rx driven with 0x3C and stop bit 0 -> done pulses, dout=0x3C, err=1; a following good 0x81 frame -> dout=0x81, err=0.
REQ-036 rx low glitch of 4 cycles in IDLE -> no done pulse; dout and err unchanged.
REQ-037 run held high, din=0x00 then 0xFF changed mid-frame -> first frame carries 0x00, second frame starts immediately after the stop bit.
REQ-038 rst_n asserted at bit 4 of a TX and an RX frame -> tx=1, done=0, dout=0x00 instantly; a new 0x5A loopback after release completes correctly.
REQ-039 Simultaneous TX of 0x12 and independent RX of 0x34 -> tx frame correct, dout=0x34, single done pulse.

Source files
------------

// File: rtl/uart_if.sv
// uart_if: transmit request/line and receive line/result signals of uart_core
//   run, din         : transmit request and byte to send
//   tx               : serial transmit line
//   rx               : serial receive line
//   dout, done, err  : received byte, frame-complete pulse, framing error
interface uart_if;
  logic       run;
  logic [7:0] din;
  logic       tx;
  logic       rx;
  logic [7:0] dout;
  logic       done;
  logic       err;
  modport master (output run, din, rx, input tx, dout, done, err);
  modport slave (input run, din, rx, output tx, dout, done, err);
endinterface

// File: rtl/uart_core.sv
// uart_core: 8N1 UART with independent transmitter and receiver FSMs
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   u      : uart_if slave (run/din/tx transmit side, rx/dout/done/err receive side)
module uart_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic   clk,
  input logic   rst_n,
  uart_if.slave u
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  // the edge detector already absorbs the synchronizer delay, so mid-start lands HALF+1 edges after START entry
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t ts, ts_n, rs, rs_n;
  logic [CW-1:0] tc, tc_n, rc, rc_n;
  logic [2:0] tbit, tbit_n, rbit, rbit_n;
  logic [7:0] tsh, tsh_n, rsh, rsh_n, dout_n;
  logic s1, s2, s3, done_n, err_n;
  always_comb begin
    ts_n = ts;
    tc_n = tc + 1'b1;
    tbit_n = tbit;
    tsh_n = tsh;
    case (ts)
      IDLE: begin
        tc_n = '0;
        if (u.run) begin
          ts_n = START;
          tsh_n = u.din;
        end
      end
      START: if (tc == LAST) begin
        ts_n = DATA;
        tc_n = '0;
        tbit_n = '0;
      end
      DATA: if (tc == LAST) begin
        tc_n = '0;
        tbit_n = tbit + 1'b1;
        if (tbit == 3'd7) ts_n = STOP;
      end
      default: if (tc == LAST) begin
        // a pending request chains straight into the next start bit
        tc_n = '0;
        ts_n = u.run ? START : IDLE;
        tsh_n = u.run ? u.din : tsh;
      end
    endcase
  end
  assign u.tx = ts == START ? 1'b0 : ts == DATA ? tsh[tbit] : 1'b1;
  always_comb begin
    rs_n = rs;
    rc_n = rc + 1'b1;
    rbit_n = rbit;
    rsh_n = rsh;
    dout_n = u.dout;
    err_n = u.err;
    done_n = 1'b0;
    case (rs)
      IDLE: begin
        rc_n = '0;
        if (s3 && !s2) rs_n = START;
      end
      START: if (rc == HALF) begin
        rc_n = '0;
        rbit_n = '0;
        rs_n = s2 ? IDLE : DATA;
      end
      DATA: if (rc == LAST) begin
        rc_n = '0;
        rbit_n = rbit + 1'b1;
        rsh_n = {s2, rsh[7:1]};
        if (rbit == 3'd7) rs_n = STOP;
      end
      default: if (rc == LAST) begin
        rc_n = '0;
        rs_n = IDLE;
        dout_n = rsh;
        err_n = !s2;
        done_n = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts <= IDLE;
      tc <= '0;
      tbit <= '0;
      tsh <= '0;
      rs <= IDLE;
      rc <= '0;
      rbit <= '0;
      rsh <= '0;
      {s1, s2, s3} <= 3'b111;
      u.dout <= '0;
      u.err <= 1'b0;
      u.done <= 1'b0;
    end else begin
      ts <= ts_n;
      tc <= tc_n;
      tbit <= tbit_n;
      tsh <= tsh_n;
      rs <= rs_n;
      rc <= rc_n;
      rbit <= rbit_n;
      rsh <= rsh_n;
      {s1, s2, s3} <= {u.rx, s1, s2};
      u.dout <= dout_n;
      u.err <= err_n;
      u.done <= done_n;
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven and scoreboard checks of uart_core
module tb_uart_core;
  localparam int CPB = 16;
  logic clk = 0;
  logic rst_n = 1;
  logic loop = 0;
  logic rx_drv = 1;
  int checks = 0;
  int passed = 0;
  int dones = 0;
  int d0;
  typedef struct {logic [7:0] d; logic stp; logic [7:0] xd; logic xe;} vec_t;
  typedef struct {logic [7:0] d; logic e;} exp_t;
  exp_t sb[$];
  vec_t v[6];
  uart_if u();
  uart_core #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst_n(rst_n), .u(u));
  assign u.rx = loop ? u.tx : rx_drv;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  always @(negedge clk) if (rst_n && u.done) begin
    exp_t e;
    dones++;
    chk("done_expected", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rx_dout", u.dout, e.d);
      chk("rx_err", u.err, e.e);
    end
  end
  task automatic check_frame(input logic [7:0] d, input string n);
    logic [9:0] f;
    int bad;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int j = 0; j < CPB; j++) begin
        if (u.tx !== f[i]) bad++;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", n, i), bad, 0);
    end
  endtask
  task automatic tx_frame(input logic [7:0] d, input string n);
    @(negedge clk);
    u.run = 1;
    u.din = d;
    @(negedge clk);
    u.run = 0;
    u.din = ~d;
    check_frame(d, n);
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stp);
    logic [9:0] f;
    f = {stp, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1;
  endtask
  task automatic drain(input string n);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4 * CPB) begin
      @(negedge clk);
      k++;
    end
    chk(n, sb.size(), 0);
    sb.delete();
  endtask
  initial begin
    v[0] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    v[1] = '{8'h81, 1'b1, 8'h81, 1'b0};
    v[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    v[3] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    v[4] = '{8'h55, 1'b1, 8'h55, 1'b0};
    v[5] = '{8'hAA, 1'b1, 8'hAA, 1'b0};
    u.run = 0;
    u.din = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_tx", u.tx, 1);
    chk("rst_dout", u.dout, 0);
    chk("rst_done", u.done, 0);
    chk("rst_err", u.err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    loop = 1;
    sb.push_back('{8'hA5, 1'b0});
    d0 = dones;
    tx_frame(8'hA5, "a5");
    drain("a5_rx");
    chk("a5_dones", dones - d0, 1);
    loop = 0;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{v[i].xd, v[i].xe});
      send_rx(v[i].d, v[i].stp);
      repeat (CPB) @(negedge clk);
      drain($sformatf("rx_vec%0d", i));
    end
    d0 = dones;
    rx_drv = 0;
    repeat (4) @(negedge clk);
    rx_drv = 1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_dones", dones - d0, 0);
    chk("glitch_dout", u.dout, v[5].xd);
    chk("glitch_err", u.err, v[5].xe);
    loop = 1;
    sb.push_back('{8'h00, 1'b0});
    sb.push_back('{8'hFF, 1'b0});
    @(negedge clk);
    u.run = 1;
    u.din = 8'h00;
    @(negedge clk);
    u.din = 8'hFF;
    fork
      begin
        check_frame(8'h00, "b2b0");
        check_frame(8'hFF, "b2b1");
      end
      begin
        repeat (15 * CPB) @(negedge clk);
        u.run = 0;
      end
    join
    chk("b2b_idle", u.tx, 1);
    drain("b2b_rx");
    @(negedge clk);
    u.run = 1;
    u.din = 8'h77;
    @(negedge clk);
    u.run = 0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    d0 = dones;
    #2 rst_n = 0;
    #1;
    chk("abort_tx", u.tx, 1);
    chk("abort_done", u.done, 0);
    chk("abort_dout", u.dout, 0);
    chk("abort_err", u.err, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (12 * CPB) @(negedge clk);
    chk("abort_dones", dones - d0, 0);
    sb.push_back('{8'h5A, 1'b0});
    tx_frame(8'h5A, "5a");
    drain("5a_rx");
    sb.push_back('{8'hC3, 1'b0});
    @(negedge clk);
    rst_n = 0;
    u.run = 1;
    u.din = 8'hC3;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    u.run = 0;
    check_frame(8'hC3, "runrst");
    drain("runrst_rx");
    loop = 0;
    repeat (CPB) @(negedge clk);
    sb.push_back('{8'h34, 1'b0});
    d0 = dones;
    fork
      tx_frame(8'h12, "conc_tx");
      send_rx(8'h34, 1'b1);
    join
    repeat (CPB) @(negedge clk);
    drain("conc_rx");
    chk("conc_dones", dones - d0, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
